// File: rtl/res129_pkg.sv
// Shared constants and types for the mod-129 residue checker.
package res129_pkg;

    localparam int MOD_VAL  = 129;
    localparam int W256_MOD = 127;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef logic [7:0] residue_t;

endpackage

// File: rtl/res129_step.sv
// One byte-serial step of the mod-129 residue: (acc*256 + b) mod 129.
// 256 folds to 127, and the 15-bit product is reduced with 128 = -1 (mod 129).
module res129_step
    import res129_pkg::*;
(
    input  residue_t    acc,
    input  logic [7:0]  b,
    output residue_t    res_next
);

    logic [14:0] prod;
    logic [8:0]  diff;

    // Multiply by 127, add the new byte, then fold the high part back in with a negative weight.
    always_comb begin
        prod = ({7'd0, acc} * 15'(W256_MOD)) + {7'd0, b};
        diff = {2'b00, prod[6:0]} - {1'b0, prod[14:7]};
        if (diff[8]) begin
            diff = diff + 9'(MOD_VAL);
        end
        res_next = diff[7:0];
    end

endmodule

// File: rtl/residue_129_checker.sv
// Byte-serial mod-129 residue checker for protected data words.
// Recomputes X mod 129 one byte per cycle (MSB byte first) and flags a mismatch
// against the received check residue or a non-canonical check value (>= 129).
// Optional feature: define RES129_SYNDROME_EN to add the out_syndrome port.
module residue_129_checker
    import res129_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [7:0]        in_check,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_residue,
`ifdef RES129_SYNDROME_EN
    output logic [7:0]        out_syndrome,
`endif
    output logic              out_err
);

    localparam int         NBYTES   = DATA_W / 8;
    localparam logic [2:0] CNT_INIT = 3'(NBYTES - 1);

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] data_q;
    residue_t          check_q;
    residue_t          acc;
    residue_t          acc_next;
    logic [2:0]        cnt;
    logic [7:0]        cur_byte;
    logic              check_bad;

    // Select the byte addressed by the down-counter; the top byte is consumed first.
    always_comb begin
        cur_byte = 8'(data_q >> {cnt, 3'b000});
    end

    res129_step u_step (
        .acc      (acc),
        .b        (cur_byte),
        .res_next (acc_next)
    );

    // State register; reset drops any word in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept in IDLE, one byte per RUN cycle, hold DONE until the consumer takes it.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid) state_next = RUN;
            RUN:  if (cnt == 3'd0) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: capture the word on accept, then fold one byte into the accumulator per RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            check_q <= '0;
            acc     <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_q  <= in_data;
                        check_q <= in_check;
                        acc     <= '0;
                        cnt     <= CNT_INIT;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    if (cnt != 3'd0) begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // A check residue of 129 or more can never come from a correct generator.
    always_comb begin
        check_bad = (check_q >= 8'(MOD_VAL));
    end

`ifdef RES129_SYNDROME_EN
    logic [7:0] check_canon;
    logic [8:0] syn_diff;

    // Syndrome is (acc - check) mod 129, using the canonical form of a non-canonical check.
    always_comb begin
        check_canon = check_bad ? (check_q - 8'(MOD_VAL)) : check_q;
        syn_diff    = {1'b0, acc} - {1'b0, check_canon};
        if (syn_diff[8]) begin
            syn_diff = syn_diff + 9'(MOD_VAL);
        end
    end
`endif

    // Outputs are decoded from the state so they follow the asynchronous reset immediately.
    always_comb begin
        in_ready    = (state == IDLE);
        out_valid   = 1'b0;
        out_residue = '0;
        out_err     = 1'b0;
`ifdef RES129_SYNDROME_EN
        out_syndrome = '0;
`endif
        if (state == DONE) begin
            out_valid   = 1'b1;
            out_residue = acc;
            out_err     = check_bad || (acc != check_q);
`ifdef RES129_SYNDROME_EN
            out_syndrome = syn_diff[7:0];
`endif
        end
    end

endmodule

// File: tb/tb_residue_129_checker.sv
// Scoreboard testbench for residue_129_checker plus an exhaustive sweep of res129_step.
module tb_residue_129_checker;

    localparam int DATA_W = 64;
    localparam int LAT    = DATA_W / 8 + 1;

    typedef struct {
        logic [7:0] res;
        logic       err;
        logic [7:0] syn;
        int         due;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [7:0]        in_check;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_residue;
    logic              out_err;
`ifdef RES129_SYNDROME_EN
    logic [7:0]        out_syndrome;
`endif

    logic [7:0] st_acc;
    logic [7:0] st_b;
    logic [7:0] st_out;

    exp_t sb[$];
    int   checks      = 0;
    int   failures    = 0;
    int   cyc         = 0;
    int   hold_left   = 0;
    bit   ready_always = 1'b1;
    bit   prev_valid  = 1'b0;
    bit   popped_prev = 1'b0;

    residue_129_checker #(.DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_check    (in_check),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_residue (out_residue),
`ifdef RES129_SYNDROME_EN
        .out_syndrome(out_syndrome),
`endif
        .out_err     (out_err)
    );

    res129_step u_step (
        .acc      (st_acc),
        .b        (st_b),
        .res_next (st_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain modular arithmetic on the whole word.
    function automatic int refMod(input logic [63:0] x);
        return int'(x % 64'd129);
    endfunction

    function automatic int refSyn(input int r, input int chk);
        return (((r - (chk % 129)) % 129) + 129) % 129;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Present one word; the expectation is queued only when the DUT actually accepts it.
    task automatic applyStimulus(input logic [63:0] data, input logic [7:0] chk,
                                 input logic [7:0] e_res, input logic e_err, input logic [7:0] e_syn);
        exp_t e;
        int   waited;
        bit   done;
        waited = 0;
        done   = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = data;
        in_check = chk;
        while (!done) begin
            #1;
            if (in_ready) begin
                e.res = e_res;
                e.err = e_err;
                e.syn = e_syn;
                e.due = cyc + LAT;
                sb.push_back(e);
                done = 1'b1;
            end else begin
                waited++;
                if (waited > 200) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL accept_timeout actual=no_accept expected=accept");
                    done = 1'b1;
                end else begin
                    @(negedge clk);
                end
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
        in_check = 8'($urandom);
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_pending", sb.size(), 0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_in_ready"}, in_ready, 1);
        checkOutput({tag, "_out_valid"}, out_valid, 0);
        checkOutput({tag, "_out_residue"}, out_residue, 0);
        checkOutput({tag, "_out_err"}, out_err, 0);
`ifdef RES129_SYNDROME_EN
        checkOutput({tag, "_out_syndrome"}, out_syndrome, 0);
`endif
    endtask

    // Monitor: compare every presented result against the queue head, and drive out_ready.
    always @(negedge clk) begin
        if (rst) begin
            popped_prev = 1'b0;
            prev_valid  = 1'b0;
        end else begin
            if (popped_prev) begin
                checkOutput("valid_drop_after_take", out_valid, 0);
                checkOutput("in_ready_after_take", in_ready, 1);
                popped_prev = 1'b0;
            end else if (out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_result actual=out_valid expected=idle residue=%0d", out_residue);
                    out_ready = 1'b1;
                end else begin
                    if (!prev_valid) checkOutput("latency_cycle", cyc, sb[0].due);
                    checkOutput("residue", out_residue, sb[0].res);
                    checkOutput("err", out_err, sb[0].err);
`ifdef RES129_SYNDROME_EN
                    checkOutput("syndrome", out_syndrome, sb[0].syn);
`endif
                    checkOutput("in_ready_in_done", in_ready, 0);
                    if (hold_left > 0) begin
                        out_ready = 1'b0;
                        hold_left--;
                    end else if (ready_always) begin
                        out_ready = 1'b1;
                    end else begin
                        out_ready = ($urandom_range(0, 3) != 0);
                    end
                    if (out_ready) begin
                        void'(sb.pop_front());
                        popped_prev = 1'b1;
                    end
                end
            end else begin
`ifdef RES129_SYNDROME_EN
                checkOutput("syndrome_idle", out_syndrome, 0);
`endif
                out_ready = 1'($urandom_range(0, 1));
            end
            prev_valid = out_valid;
        end
    end

    // Main sequence: reset, step sweep, directed cases, backpressure, mid-run reset, random words.
    initial begin
        int errs;
        int first_a;
        int first_b;
        int first_got;
        logic [63:0] d;
        int r;
        int c;
        int mode;
        logic e;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_check  = '0;
        out_ready = 1'b0;
        st_acc    = '0;
        st_b      = '0;
        repeat (2) @(negedge clk);
        #1;
        checkResetValues("reset");
        rst = 1'b0;

        errs = 0;
        first_a = 0;
        first_b = 0;
        first_got = 0;
        for (int a = 0; a <= 128; a++) begin
            for (int b = 0; b <= 255; b++) begin
                st_acc = 8'(a);
                st_b   = 8'(b);
                #1;
                if (int'(st_out) != ((a * 256 + b) % 129)) begin
                    if (errs == 0) begin
                        first_a   = a;
                        first_b   = b;
                        first_got = int'(st_out);
                    end
                    errs++;
                end
            end
        end
        checks++;
        if (errs != 0) begin
            failures++;
            $display("[TB] FAIL step_sweep bad_pairs=%0d first acc=%0d b=%0d actual=%0d expected=%0d",
                     errs, first_a, first_b, first_got, (first_a * 256 + first_b) % 129);
        end

        ready_always = 1'b1;
        applyStimulus(64'd2721979, 8'd79, 8'd79, 1'b0, 8'd0);
        applyStimulus(64'd623541, 8'd84, 8'd84, 1'b0, 8'd0);
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 8'd126, 8'd126, 1'b0, 8'd0);
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 8'd200, 8'd126, 1'b1, 8'd55);
        applyStimulus(64'd623541, 8'd90, 8'd84, 1'b1, 8'd123);
        applyStimulus(64'd623541, 8'd80, 8'd84, 1'b1, 8'd4);
        applyStimulus(64'd0, 8'd0, 8'd0, 1'b0, 8'd0);
        applyStimulus(64'd128, 8'd128, 8'd128, 1'b0, 8'd0);
        applyStimulus(64'd129, 8'd129, 8'd0, 1'b1, 8'd0);
        waitDrain();

        $display("[TB] backpressure");
        hold_left = 5;
        applyStimulus(64'd2721979, 8'd79, 8'd79, 1'b0, 8'd0);
        applyStimulus(64'd623541, 8'd84, 8'd84, 1'b0, 8'd0);
        waitDrain();

        $display("[TB] reset during RUN");
        applyStimulus(64'd41290864012, 8'd19, 8'd19, 1'b0, 8'd0);
        repeat (3) @(posedge clk);
        #2;
        checkOutput("in_ready_in_run", in_ready, 0);
        rst = 1'b1;
        #1;
        checkResetValues("midrun_reset");
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(64'd41290864012, 8'd19, 8'd19, 1'b0, 8'd0);
        waitDrain();

        $display("[TB] random words");
        ready_always = 1'b0;
        for (int i = 0; i < 40; i++) begin
            d = (i % 5 == 0) ? 64'($urandom_range(0, 300)) : {$urandom, $urandom};
            r = refMod(d);
            mode = $urandom_range(0, 3);
            if (mode <= 1)      c = r;
            else if (mode == 2) c = $urandom_range(0, 255);
            else if (r <= 126)  c = r + 129;
            else                c = $urandom_range(129, 255);
            e = (c >= 129) || (c != r);
            applyStimulus(d, 8'(c), 8'(r), e, 8'(refSyn(r, c)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        waitDrain();
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so a stuck DUT still ends with a summary.
    initial begin
        #500000;
        failures++;
        $display("[TB] FAIL watchdog actual=timeout expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
